// File: rtl/axi_master_bridge.sv
// Single-outstanding AXI4 master: turns one CPU load/store into one single-beat AXI read or write.
// All AXI handshake outputs and the CPU response are registered.
module axi_master_bridge #(
    parameter int unsigned       ID_W      = 4,
    parameter logic [ID_W-1:0]   MASTER_ID = '0,
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                req_valid,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                req_ready,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,

    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARAddr,
    output logic [3:0]          M_ARLen,
    output logic [2:0]          M_ARSize,
    output logic [1:0]          M_ARBurst,
    output logic                M_ARValid,
    input  logic                M_ARReady,

    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RData,
    input  logic [1:0]          M_RResp,
    input  logic                M_RLast,
    input  logic                M_RValid,
    output logic                M_RReady,

    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWAddr,
    output logic [3:0]          M_AWLen,
    output logic [2:0]          M_AWSize,
    output logic [1:0]          M_AWBurst,
    output logic                M_AWValid,
    input  logic                M_AWReady,

    output logic [DATA_W-1:0]   M_WData,
    output logic [DATA_W/8-1:0] M_WStrb,
    output logic                M_WLast,
    output logic                M_WValid,
    input  logic                M_WReady,

    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BResp,
    input  logic                M_BValid,
    output logic                M_BReady
);

    typedef enum logic [2:0] {StIdle, StRaddr, StRdata, StWreq, StWresp} state_e;

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  r_ready_q, r_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  aw_done_q, aw_done_d;
    logic                  w_done_q, w_done_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;

    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic unused_resp;

    assign ar_hs = ar_valid_q & M_ARReady;
    assign r_hs  = r_ready_q & M_RValid;
    assign aw_hs = aw_valid_q & M_AWReady;
    assign w_hs  = w_valid_q & M_WReady;
    assign b_hs  = b_ready_q & M_BValid;

    // Only RESP[1] distinguishes SLVERR/DECERR from OKAY/EXOKAY.
    assign unused_resp = M_RResp[0] ^ M_BResp[0];

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rdata_d     = rdata_q;
        ar_valid_d  = ar_valid_q;
        r_ready_d   = r_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        b_ready_d   = b_ready_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid && req_ready_q) begin
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    wstrb_d     = req_wstrb;
                    req_ready_d = 1'b0;
                    if (req_write) begin
                        state_d    = StWreq;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = StRaddr;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            StRaddr: begin
                if (ar_hs) begin
                    ar_valid_d = 1'b0;
                    r_ready_d  = 1'b1;
                    state_d    = StRdata;
                end
            end
            StRdata: begin
                if (r_hs) begin
                    rdata_d     = M_RData;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = M_RResp[1] || (M_RID != MASTER_ID) || !M_RLast;
                    r_ready_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            StWreq: begin
                if (aw_hs) begin
                    aw_valid_d = 1'b0;
                    aw_done_d  = 1'b1;
                end
                if (w_hs) begin
                    w_valid_d = 1'b0;
                    w_done_d  = 1'b1;
                end
                // Channels finish independently; advance once both have.
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    b_ready_d = 1'b1;
                    state_d   = StWresp;
                end
            end
            StWresp: begin
                if (b_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = M_BResp[1] || (M_BID != MASTER_ID);
                    b_ready_d   = 1'b0;
                    req_ready_d = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rdata_q     <= '0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            b_ready_q   <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rdata_q     <= rdata_d;
            ar_valid_q  <= ar_valid_d;
            r_ready_q   <= r_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            b_ready_q   <= b_ready_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rsp_err_q;

    assign M_ARID    = MASTER_ID;
    assign M_ARAddr  = addr_q;
    assign M_ARLen   = 4'd0;
    assign M_ARSize  = 3'b010;
    assign M_ARBurst = 2'b01;
    assign M_ARValid = ar_valid_q;
    assign M_RReady  = r_ready_q;

    assign M_AWID    = MASTER_ID;
    assign M_AWAddr  = addr_q;
    assign M_AWLen   = 4'd0;
    assign M_AWSize  = 3'b010;
    assign M_AWBurst = 2'b01;
    assign M_AWValid = aw_valid_q;

    assign M_WData   = wdata_q;
    assign M_WStrb   = wstrb_q;
    assign M_WLast   = 1'b1;
    assign M_WValid  = w_valid_q;
    assign M_BReady  = b_ready_q;

endmodule

// File: tb/tb_axi_master_bridge.sv
// Directed bench for axi_master_bridge: the bench plays the AXI slave, drives at negedge, samples at negedge.
module tb_axi_master_bridge;

    logic        clk;
    logic        rst;
    logic        req_valid, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [3:0]  M_ARID, M_RID, M_AWID, M_BID;
    logic [31:0] M_ARAddr, M_AWAddr, M_RData, M_WData;
    logic [3:0]  M_ARLen, M_AWLen, M_WStrb;
    logic [2:0]  M_ARSize, M_AWSize;
    logic [1:0]  M_ARBurst, M_AWBurst, M_RResp, M_BResp;
    logic        M_ARValid, M_ARReady, M_RLast, M_RValid, M_RReady;
    logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
    logic        M_BValid, M_BReady;

    int n_cmp = 0;
    int n_err = 0;

    axi_master_bridge dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen), .M_ARSize(M_ARSize),
        .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady),
        .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen), .M_AWSize(M_AWSize),
        .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
        .M_WReady(M_WReady),
        .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid), .M_BReady(M_BReady)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        M_ARReady = 0; M_RID = 0; M_RData = 0; M_RResp = 0; M_RLast = 1; M_RValid = 0;
        M_AWReady = 0; M_WReady = 0; M_BID = 0; M_BResp = 0; M_BValid = 0;
        tick(); tick();
        rst = 1'b1;
        tick();
        n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if ({M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady} !== 5'b0) begin
            n_err++; $display("FAIL reset_handshakes: got %b want 00000",
                              {M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady});
        end
        n_cmp++; if ({rsp_valid, rsp_err} !== 2'b00) begin n_err++; $display("FAIL reset_rsp: got %b want 00", {rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if ({M_ARLen, M_ARSize, M_ARBurst, M_ARID} !== {4'd0, 3'b010, 2'b01, 4'd0}) begin
            n_err++; $display("FAIL ar_constants: got %h want %h", {M_ARLen, M_ARSize, M_ARBurst, M_ARID},
                              {4'd0, 3'b010, 2'b01, 4'd0});
        end
        n_cmp++; if ({M_AWLen, M_AWSize, M_AWBurst, M_AWID, M_WLast} !== {4'd0, 3'b010, 2'b01, 4'd0, 1'b1}) begin
            n_err++; $display("FAIL aw_constants: got %h want %h", {M_AWLen, M_AWSize, M_AWBurst, M_AWID, M_WLast},
                              {4'd0, 3'b010, 2'b01, 4'd0, 1'b1});
        end
    endtask

    task automatic test_load_wait();
        int ar_cycles;
        req_valid = 1; req_write = 0; req_addr = 32'h1000_0100;
        tick();
        req_valid = 0;
        n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL load_req_ready_busy: got %b want 0", req_ready); end
        ar_cycles = 0;
        for (int i = 0; i < 3; i++) begin
            if (M_ARValid === 1'b1 && M_ARAddr === 32'h1000_0100) ar_cycles++;
            if (i == 2) M_ARReady = 1;
            tick();
        end
        M_ARReady = 0;
        n_cmp++; if (ar_cycles !== 3) begin n_err++; $display("FAIL load_ar_held: got %0d cycles want 3", ar_cycles); end
        n_cmp++; if ({M_ARValid, M_RReady} !== 2'b01) begin n_err++; $display("FAIL load_ar_to_r: got %b want 01", {M_ARValid, M_RReady}); end
        M_RValid = 1; M_RData = 32'hDEAD_BEEF; M_RID = 0; M_RResp = 2'b00; M_RLast = 1;
        tick();
        M_RValid = 0;
        n_cmp++; if ({rsp_valid, rsp_err, req_ready, M_RReady} !== 4'b1010) begin
            n_err++; $display("FAIL load_rsp: got %b want 1010", {rsp_valid, rsp_err, req_ready, M_RReady});
        end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rdata: got %h want deadbeef", rsp_rdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL load_rsp_pulse: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL load_rdata_hold: got %h want deadbeef", rsp_rdata); end
    endtask

    task automatic test_store_w_first();
        req_valid = 1; req_write = 1; req_addr = 32'h1001_0200; req_wdata = 32'h1; req_wstrb = 4'hF;
        tick();
        req_valid = 0; req_write = 0;
        n_cmp++; if ({M_AWValid, M_WValid, M_ARValid} !== 3'b110) begin
            n_err++; $display("FAIL store_valids_rise: got %b want 110", {M_AWValid, M_WValid, M_ARValid});
        end
        n_cmp++; if ({M_AWAddr, M_WData, M_WStrb} !== {32'h1001_0200, 32'h1, 4'hF}) begin
            n_err++; $display("FAIL store_payload: got %h want %h", {M_AWAddr, M_WData, M_WStrb},
                              {32'h1001_0200, 32'h1, 4'hF});
        end
        M_WReady = 1;
        tick();
        M_WReady = 0;
        n_cmp++; if ({M_AWValid, M_WValid, M_BReady} !== 3'b100) begin
            n_err++; $display("FAIL store_w_drops_first: got %b want 100", {M_AWValid, M_WValid, M_BReady});
        end
        tick();
        n_cmp++; if ({M_AWValid, M_AWAddr} !== {1'b1, 32'h1001_0200}) begin
            n_err++; $display("FAIL store_aw_hold: got %h want %h", {M_AWValid, M_AWAddr}, {1'b1, 32'h1001_0200});
        end
        tick();
        M_AWReady = 1;
        tick();
        M_AWReady = 0;
        n_cmp++; if ({M_AWValid, M_WValid, M_BReady} !== 3'b001) begin
            n_err++; $display("FAIL store_to_wresp: got %b want 001", {M_AWValid, M_WValid, M_BReady});
        end
        M_BValid = 1; M_BResp = 2'b00; M_BID = 0;
        tick();
        M_BValid = 0;
        n_cmp++; if ({rsp_valid, rsp_err, req_ready, M_BReady} !== 4'b1010) begin
            n_err++; $display("FAIL store_rsp: got %b want 1010", {rsp_valid, rsp_err, req_ready, M_BReady});
        end
        n_cmp++; if (rsp_rdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL store_rdata_kept: got %h want deadbeef", rsp_rdata); end
        tick();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL store_one_b: got %b want 0", rsp_valid); end
    endtask

    task automatic test_store_same_cycle_err();
        req_valid = 1; req_write = 1; req_addr = 32'h2000_0004; req_wdata = 32'hCAFE_F00D; req_wstrb = 4'h3;
        tick();
        req_valid = 0; req_write = 0;
        M_AWReady = 1; M_WReady = 1;
        tick();
        M_AWReady = 0; M_WReady = 0;
        n_cmp++; if ({M_AWValid, M_WValid, M_BReady} !== 3'b001) begin
            n_err++; $display("FAIL store_same_cycle: got %b want 001", {M_AWValid, M_WValid, M_BReady});
        end
        M_BValid = 1; M_BResp = 2'b10;
        tick();
        M_BValid = 0; M_BResp = 2'b00;
        n_cmp++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_err++; $display("FAIL store_slverr: got %b want 11", {rsp_valid, rsp_err}); end
    endtask

    task automatic test_load_id_err();
        req_valid = 1; req_write = 0; req_addr = 32'h3000_0000;
        tick();
        req_valid = 0;
        M_ARReady = 1;
        tick();
        M_ARReady = 0;
        M_RValid = 1; M_RID = 4'd5; M_RResp = 2'b00; M_RData = 32'h1234_5678; M_RLast = 1;
        tick();
        M_RValid = 0; M_RID = 0;
        n_cmp++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_err++; $display("FAIL load_id_err: got %b want 11", {rsp_valid, rsp_err}); end
        n_cmp++; if (rsp_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL load_id_err_rdata: got %h want 12345678", rsp_rdata); end
        // Missing RLast is also an error.
        req_valid = 1; req_addr = 32'h3000_0008;
        tick();
        req_valid = 0;
        M_ARReady = 1;
        tick();
        M_ARReady = 0;
        M_RValid = 1; M_RData = 32'h0BAD_0BAD; M_RLast = 0;
        tick();
        M_RValid = 0; M_RLast = 1;
        n_cmp++; if ({rsp_valid, rsp_err} !== 2'b11) begin n_err++; $display("FAIL load_nolast_err: got %b want 11", {rsp_valid, rsp_err}); end
    endtask

    task automatic test_stray_response();
        tick();
        M_BValid = 1; M_RValid = 1;
        tick(); tick();
        n_cmp++; if ({rsp_valid, M_BReady, M_RReady, req_ready} !== 4'b0001) begin
            n_err++; $display("FAIL stray_ignored: got %b want 0001", {rsp_valid, M_BReady, M_RReady, req_ready});
        end
        M_BValid = 0; M_RValid = 0;
    endtask

    task automatic test_back_to_back();
        req_valid = 1; req_write = 0; req_addr = 32'h4000_0000;
        tick();
        req_addr = 32'h4000_0040;
        M_ARReady = 1;
        tick();
        M_ARReady = 0;
        M_RValid = 1; M_RData = 32'hAAAA_0001;
        tick();
        M_RValid = 0;
        n_cmp++; if ({rsp_valid, req_ready, rsp_rdata} !== {2'b11, 32'hAAAA_0001}) begin
            n_err++; $display("FAIL b2b_first_rsp: got %h want %h", {rsp_valid, req_ready, rsp_rdata}, {2'b11, 32'hAAAA_0001});
        end
        tick();
        req_valid = 0;
        n_cmp++; if ({M_ARValid, M_ARAddr, req_ready, rsp_valid} !== {1'b1, 32'h4000_0040, 2'b00}) begin
            n_err++; $display("FAIL b2b_second_ar: got %h want %h", {M_ARValid, M_ARAddr, req_ready, rsp_valid},
                              {1'b1, 32'h4000_0040, 2'b00});
        end
        M_ARReady = 1;
        tick();
        M_ARReady = 0;
        M_RValid = 1; M_RData = 32'hAAAA_0002;
        tick();
        M_RValid = 0;
        n_cmp++; if ({rsp_valid, rsp_err, rsp_rdata} !== {2'b10, 32'hAAAA_0002}) begin
            n_err++; $display("FAIL b2b_second_rsp: got %h want %h", {rsp_valid, rsp_err, rsp_rdata}, {2'b10, 32'hAAAA_0002});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        req_valid = 1; req_write = 1; req_addr = 32'h5000_0000; req_wdata = 32'h55; req_wstrb = 4'h1;
        tick();
        req_valid = 0; req_write = 0;
        n_cmp++; if ({M_AWValid, M_WValid} !== 2'b11) begin n_err++; $display("FAIL mid_pre: got %b want 11", {M_AWValid, M_WValid}); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if ({M_AWValid, M_WValid, req_ready} !== 3'b001) begin
            n_err++; $display("FAIL mid_async_clear: got %b want 001", {M_AWValid, M_WValid, req_ready});
        end
        tick(); tick();
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid !== 1'b0) pulses++;
        end
        n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL mid_no_rsp: got %0d pulses want 0", pulses); end
        n_cmp++; if ({req_ready, M_AWValid, M_WValid, M_BReady, rsp_rdata} !== {4'b1000, 32'h0}) begin
            n_err++; $display("FAIL mid_idle: got %h want %h", {req_ready, M_AWValid, M_WValid, M_BReady, rsp_rdata},
                              {4'b1000, 32'h0});
        end
    endtask

    initial begin
        test_reset();
        test_load_wait();
        test_store_w_first();
        test_store_same_cycle_err();
        test_load_id_err();
        test_stray_response();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
